chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
- Parametrised multi-cycle successor to the single-bit gate-level half adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, through a registered carry chain.
- Valid/ready handshakes on input and output; reports Sum, Carry and signed Overflow.
- Used wherever a narrow adder must be time-shared to save area, e.g. slow datapaths and accumulators.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per clock; 1 <= CHUNK <= WIDTH.
- NCHUNK = WIDTH/CHUNK is derived, not overridable. The index counter is clog2(NCHUNK) bits, minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands A, B, Cin valid.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  A+B+Cin modulo 2^WIDTH.
- Carry  output  1  carry-out of bit WIDTH-1.
- Overflow  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. rst_n low immediately forces state=IDLE and clears all registers: operand regs, carry reg, index, Sum=0, Carry=0, Overflow=0, out_valid=0.
- in_ready = (state==IDLE). No transfer is taken while rst_n is low.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid && in_ready at a rising edge: register A, B; carry_reg<=Cin; idx<=0; go to RUN.
- RUN (NCHUNK cycles):
  - in_ready=0, out_valid=0.
  - Each edge: {c,s} = A[idx*CHUNK +: CHUNK] + B[idx*CHUNK +: CHUNK] + carry_reg, computed at CHUNK+1 bits.
  - Sum_reg[idx chunk]<=s; carry_reg<=c; idx<=idx+1.
  - At the edge where idx==NCHUNK-1: Carry<=c; Overflow<=(A[W-1]==B[W-1]) && (s[CHUNK-1]!=A[W-1]); go to DONE.
- DONE:
  - out_valid=1. Sum, Carry, Overflow are held stable while out_ready=0, for unbounded backpressure.
  - When out_ready=1 at an edge: go to IDLE.
  - Result registers keep their value after this; they are don't-care while out_valid=0.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge.
- Minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK run cycles, one DONE cycle. There is no overlap of operations.
- Operand inputs are sampled only at the accept edge. Changes to A/B/Cin afterwards do not affect the result.
- Sum chunks from the previous operation are fully overwritten during RUN. No stale bits may survive.
- Degenerate CHUNK==WIDTH: a single RUN cycle, latency 1.
- CHUNK=1 is a pure bit-serial adder, latency WIDTH.
- in_valid during RUN/DONE is ignored, not queued. out_ready in IDLE/RUN has no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result lost. The block is in IDLE with in_ready=1 on the first edge after rst_n rises.
- Idx wrap: idx never exceeds NCHUNK-1. It is reset to 0 on each accept.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- A=0xFFFF, B=0x0001, Cin=0 -> out_valid exactly 4 cycles after accept; Sum=0x0000, Carry=1, Overflow=0.
- A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Carry=0, Overflow=1. Then A=0x8000, B=0x8000 -> Sum=0x0000, Carry=1, Overflow=1.
- A=0x1234, B=0x4321, Cin=1 -> Sum=0x5556, Carry=0. Also A=0x0FFF, B=0x0001 -> Sum=0x1000, confirming carry propagation across chunk boundaries.
- Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid, Sum, Carry, Overflow constant and in_ready=0. in_valid pulses during RUN/DONE are ignored. Next accept only after out_ready=1.
- Reset: assert rst_n=0 asynchronously in the 2nd RUN cycle -> out_valid=0, Sum=0 immediately. After release, a new op (0x0003+0x0004) gives Sum=0x0007.
- Parameter sweep: CHUNK=1, 4, 16 with random 1000 ops each against A+B+Cin -> all results match; latency is 16, 4 and 1 respectively.

Source files
------------

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder: WIDTH-bit adder time-shared over CHUNK-bit slices through a registered carry,
// with valid/ready handshakes and signed overflow reporting.
module chunked_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry,
   output logic             Overflow
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] a_reg, b_reg, sum_nx;
   logic carry_reg;
   logic [IW-1:0] idx;
   logic [31:0] base;
   logic [CHUNK:0] csum;
   logic last;
   // Slices are taken by shifting so the chunk index never needs a variable part-select.
   always_comb begin
      base = 32'(idx) * 32'(CHUNK);
      csum = {1'b0, CHUNK'(a_reg >> base)} + {1'b0, CHUNK'(b_reg >> base)} + {{CHUNK{1'b0}}, carry_reg};
      sum_nx = (Sum & ~(MASK << base)) | (WIDTH'(csum[CHUNK-1:0]) << base);
      last = idx == IW'(NCHUNK - 1);
      in_ready = state == IDLE;
      out_valid = state == DONE;
      state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) :
                                 (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg <= '0;
         b_reg <= '0;
         carry_reg <= 1'b0;
         idx <= '0;
         Sum <= '0;
         Carry <= 1'b0;
         Overflow <= 1'b0;
      end else if (in_valid && in_ready) begin
         a_reg <= A;
         b_reg <= B;
         carry_reg <= Cin;
         idx <= '0;
      end else if (state == RUN) begin
         Sum <= sum_nx;
         carry_reg <= csum[CHUNK];
         idx <= last ? '0 : idx + IW'(1);
         if (last) begin
            Carry <= csum[CHUNK];
            Overflow <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (csum[CHUNK-1] != a_reg[WIDTH-1]);
         end
      end
   end
endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder: scoreboard bench driving CHUNK=1, 4 and 16 instances against an arithmetic model.
module tb_chunked_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic iv[3], ir[3], ov[3], ordy[3], cin[3], cy[3], of[3], busy[3];
   logic [15:0] a[3], b[3], s[3];
   typedef struct {
      logic [15:0] s;
      logic c;
      logic o;
      int acc;
   } exp_t;
   exp_t sbq[3][$];
   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s lane%0d: got 0x%0h, expected 0x%0h", nm, l, act, exp);
   endfunction
   function automatic exp_t model(logic [15:0] av, logic [15:0] bv, logic cv, int acc);
      exp_t m;
      int u, sg;
      u = int'(av) + int'(bv) + int'(cv);
      sg = int'($signed(av)) + int'($signed(bv)) + int'(cv);
      m.s = u[15:0];
      m.c = u > 65535;
      m.o = sg > 32767 || sg < -32768;
      m.acc = acc;
      return m;
   endfunction
   for (genvar g = 0; g < 3; g++) begin : ln
      localparam int LAT = g == 0 ? 16 : g == 1 ? 4 : 1;
      chunked_serial_adder #(.WIDTH(16), .CHUNK(g == 0 ? 1 : g == 1 ? 4 : 16)) dut (
         .clk(clk), .rst_n(rst_n), .in_valid(iv[g]), .in_ready(ir[g]),
         .A(a[g]), .B(b[g]), .Cin(cin[g]), .out_valid(ov[g]), .out_ready(ordy[g]),
         .Sum(s[g]), .Carry(cy[g]), .Overflow(of[g])
      );
      logic pv = 1'b0;
      exp_t e;
      always @(negedge clk) begin
         if (rst_n && ov[g] && !pv) begin
            if (sbq[g].size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_out lane%0d: out_valid=1 with no pending op, Sum=0x%0h", g, s[g]);
            end else begin
               e = sbq[g].pop_front();
               chk("sum", g, s[g], e.s);
               chk("carry", g, cy[g], e.c);
               chk("overflow", g, of[g], e.o);
               chk("latency", g, cyc - e.acc, LAT);
            end
         end
         pv <= ov[g];
      end
   end
   function automatic logic [15:0] rnd16();
      int k = $urandom_range(0, 7);
      return k == 0 ? 16'hFFFF : k == 1 ? 16'h8000 : k == 2 ? 16'h7FFF : k == 3 ? 16'h0000 : 16'($urandom);
   endfunction
   task automatic op(int l, logic [15:0] av, logic [15:0] bv, logic cv);
      int t = 0;
      @(negedge clk);
      a[l] = av;
      b[l] = bv;
      cin[l] = cv;
      iv[l] = 1'b1;
      while (!ir[l] && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!ir[l]) begin
         n_chk++;
         $display("FAIL accept_timeout lane%0d: in_ready=0 for %0d cycles, expected 1", l, t);
         iv[l] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      sbq[l].push_back(model(av, bv, cv, cyc));
      iv[l] = 1'b0;
      a[l] = 16'($urandom);
      b[l] = 16'($urandom);
      cin[l] = 1'($urandom);
   endtask
   task automatic drain(int l);
      int t = 0;
      while (sbq[l].size() != 0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (sbq[l].size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout lane%0d: %0d results pending, expected 0", l, sbq[l].size());
         sbq[l].delete();
      end
   endtask
   task automatic lane(int l);
      for (int i = 0; i < 1000; i++) begin
         op(l, rnd16(), rnd16(), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain(l);
      busy[l] = 1'b0;
   endtask
   task automatic rnd_ready(int l);
      while (busy[l]) begin
         @(negedge clk);
         ordy[l] = $urandom_range(0, 3) != 0;
      end
      ordy[l] = 1'b1;
   endtask
   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "time limit");
   end
   initial begin
      int t;
      for (int l = 0; l < 3; l++) begin
         iv[l] = 1'b0;
         ordy[l] = 1'b1;
         a[l] = '0;
         b[l] = '0;
         cin[l] = 1'b0;
         busy[l] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int l = 0; l < 3; l++) begin
         chk("rst_out_valid", l, ov[l], 0);
         chk("rst_in_ready", l, ir[l], 1);
      end
      chk("rst_sum", 1, s[1], 0);
      chk("rst_carry", 1, cy[1], 0);
      chk("rst_ovf", 1, of[1], 0);
      rst_n = 1'b1;
      op(1, 16'hFFFF, 16'h0001, 1'b0);
      drain(1);
      op(1, 16'h7FFF, 16'h0001, 1'b0);
      drain(1);
      op(1, 16'h8000, 16'h8000, 1'b0);
      drain(1);
      op(1, 16'h1234, 16'h4321, 1'b1);
      drain(1);
      op(1, 16'h0FFF, 16'h0001, 1'b0);
      drain(1);
      // Backpressure: stray in_valid pulses while busy must be dropped.
      ordy[1] = 1'b0;
      op(1, 16'h1234, 16'h0001, 1'b0);
      @(negedge clk);
      iv[1] = 1'b1;
      a[1] = 16'h5555;
      b[1] = 16'h5555;
      @(negedge clk);
      iv[1] = 1'b0;
      t = 0;
      while (!ov[1] && t < 20) begin
         @(negedge clk);
         t++;
      end
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 1, ov[1], 1);
         chk("bp_ready", 1, ir[1], 0);
         chk("bp_sum", 1, s[1], 16'h1235);
         chk("bp_carry", 1, cy[1], 0);
         chk("bp_ovf", 1, of[1], 0);
         iv[1] = i == 2;
         @(negedge clk);
      end
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      repeat (10) @(negedge clk);
      chk("bp_released_ready", 1, ir[1], 1);
      op(1, 16'h1111, 16'h2222, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 1, ov[1], 0);
      chk("arst_sum", 1, s[1], 0);
      chk("arst_ready", 1, ir[1], 1);
      sbq[1].delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 1, ir[1], 1);
      op(1, 16'h0003, 16'h0004, 1'b0);
      drain(1);
      fork
         lane(0);
         lane(1);
         lane(2);
         rnd_ready(0);
         rnd_ready(1);
         rnd_ready(2);
      join
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
